// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding access, req/ack with wait states.
// Optional byte-lane stores are enabled with DMEM_BYTE_EN_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [3:0]  in_be;
  logic [AW-1:0] idx;
  logic        bad;
  logic        resp_entry;
  logic        mem_we;

`ifdef DMEM_BYTE_EN_EN
  assign in_be = be;
`else
  assign in_be = 4'hF;
`endif

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the live inputs must be used there instead of the captured copy.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_we    = we_q;
    cur_be    = be_q;
    if (state_q == S_IDLE) begin
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_we    = we;
      cur_be    = in_be;
    end
  end

  assign idx = cur_addr[AW+1:2];
  assign bad = (cur_addr[1:0] != 2'b00) ||
               ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
          be_d    = in_be;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    resp_entry = (state_d == S_RESP) && (state_q != S_RESP);
    if (resp_entry) begin
      err_d = bad;
      if (!cur_we && !bad) rdata_d = mem[idx];
    end
  end

  assign mem_we = resp_entry && cur_we && !bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign ack   = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign err   = ack & err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder.
// Byte-lane cases run when DMEM_BYTE_EN_EN is defined (zero wait states).
module tb_dmem_responder;

  localparam int DEPTH = 1024;
`ifdef DMEM_BYTE_EN_EN
  localparam int W = 0;
`else
  localparam int W = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'hF;
  logic        ack;
  logic        err;
  logic        busy;
  logic [31:0] rdata;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
`ifdef DMEM_BYTE_EN_EN
    .be(be),
`endif
    .ack(ack),
    .rdata(rdata),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [int];
  logic [31:0] m_rdata = 32'd0;
  int          checks = 0;
  int          failures = 0;
  int          last_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input int i);
    return mdl.exists(i) ? mdl[i] : 32'h0;
  endfunction

  task automatic access(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input bit mangle, input bit hold,
                        input string tag);
    exp_t        e;
    logic        bad;
    int          idx;
    logic [3:0]  lanes;
    logic [31:0] cur;
    int          n;
    bit          got;
    idx = int'(a[31:2]);
    bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
`ifdef DMEM_BYTE_EN_EN
    lanes = b;
`else
    lanes = 4'hF;
`endif
    if (!bad && w) begin
      cur = mrd(idx);
      for (int i = 0; i < 4; i++)
        if (lanes[i]) cur[8*i +: 8] = d[8*i +: 8];
      mdl[idx] = cur;
    end
    if (!bad && !w) m_rdata = mrd(idx);
    e.err   = bad;
    e.rdata = m_rdata;
    sbq.push_back(e);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "/busy"}, 32'(busy), 32'd1);
      if (mangle) begin
        req   = 1'b0;
        addr  = a + 32'h4;
        wdata = ~d;
      end
      if (ack) got = 1'b1;
    end
    chk({tag, "/ack_seen"}, 32'(got), 32'd1);
    chk({tag, "/latency"}, 32'(n), 32'(W + 1));
    e = sbq.pop_front();
    chk({tag, "/err"}, 32'(err), 32'(e.err));
    chk({tag, "/rdata"}, rdata, e.rdata);
    last_ack = cyc;
    if (!hold) req = 1'b0;
  endtask

  initial begin
    int acks;
    int t0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst/ack", 32'(ack), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/rdata", rdata, 32'd0);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack || busy) acks++;
    end
    chk("idle/acks", 32'(acks), 32'd0);

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, "st10");
    access(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, "ld10");
    access(1'b1, 32'h13, 32'h12345678, 4'hF, 1'b0, 1'b0, "st13_mis");
    access(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, "ld10_after_mis");
    access(1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, 1'b0, 1'b0, "ld_oor");
    access(1'b0, 32'h16, 32'h0, 4'hF, 1'b0, 1'b0, "ld_mis");
    access(1'b1, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, "pre30");
    access(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b1, 1'b0, "st20_drop");
    access(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, "ld20");
    access(1'b0, 32'h24, 32'h0, 4'hF, 1'b0, 1'b0, "ld24_untouched");

    access(1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, "st50_hold");
    t0 = last_ack;
    access(1'b0, 32'h50, 32'h0, 4'hF, 1'b0, 1'b0, "ld50_raw");
    chk("b2b/gap", 32'(last_ack - t0), 32'(W + 2));

    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h30;
    wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst/ack", 32'(ack), 32'd0);
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/err", 32'(err), 32'd0);
    chk("midrst/rdata", rdata, 32'd0);
    if (W == 0) mdl[32'h30 >> 2] = 32'hA5A5A5A5;
    m_rdata = 32'd0;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    access(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, "ld30_after_rst");

`ifdef DMEM_BYTE_EN_EN
    access(1'b1, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, "be_clr40");
    access(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, "be_st40");
    access(1'b0, 32'h40, 32'h0, 4'b0000, 1'b0, 1'b0, "be_ld40");
    chk("be/value", rdata, 32'h00BB00DD);
    access(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, "be_none");
    access(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, "be_ld40b");
    access(1'b1, 32'h40, 32'h11223344, 4'b1010, 1'b0, 1'b0, "be_st40c");
    access(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, "be_ld40c");
`else
    access(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, "st_top");
    access(1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, 1'b0, "ld_top");
    access(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, "st40_full");
    access(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, "ld40_full");
`endif

    chk("sb/empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
